uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_cfg : UART receiver (majority-vote sampling) with FWFT receive FIFO
// rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int PRESCALER  = 104,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 ready,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int CW  = $clog2(PRESCALER);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam int EW  = DATA_BITS + 2;

  localparam logic [CW-1:0]  C_HM1       = CW'(PRESCALER / 2 - 1);
  localparam logic [CW-1:0]  C_H         = CW'(PRESCALER / 2);
  localparam logic [CW-1:0]  C_HP1       = CW'(PRESCALER / 2 + 1);
  localparam logic [CW-1:0]  C_HP2       = CW'(PRESCALER / 2 + 2);
  localparam logic [CW-1:0]  C_END       = CW'(PRESCALER - 1);
  localparam logic [3:0]     C_LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic           C_LAST_STOP = (STOP_BITS == 2);
  localparam logic [AW1-1:0] C_FULL      = AW1'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  // synchronizer; r_rx_d holds the previous synchronized value for edge detect
  logic r_sync1, r_sync2, r_rx_d;
  logic w_rx, w_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  assign w_rx   = r_sync2;
  assign w_fall = r_rx_d & ~w_rx;

  state_t               r_state, w_state_nx;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_bit_idx;
  logic                 r_stop_idx;
  logic                 r_s0, r_s1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr, r_ferr;
  logic                 w_maj, w_push, w_at_end;

  assign w_maj    = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_at_end = (r_cnt == C_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_push     = 1'b0;
    case (r_state)
      S_IDLE:   if (w_fall) w_state_nx = S_START;
      S_START: begin
        if (r_cnt == C_HP1 && w_maj) w_state_nx = S_IDLE;
        else if (w_at_end)           w_state_nx = S_DATA;
      end
      S_DATA: begin
        if (w_at_end && r_bit_idx == C_LAST_BIT)
          w_state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (w_at_end) w_state_nx = S_STOP;
      // push one cycle after the final stop-bit vote, not at bit end
      S_STOP: begin
        if (r_cnt == C_HP2 && r_stop_idx == C_LAST_STOP) begin
          w_push     = 1'b1;
          w_state_nx = r_ferr ? S_WAIT_IDLE : S_IDLE;
        end
      end
      S_WAIT_IDLE: if (w_rx) w_state_nx = S_IDLE;
      default:     w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_at_end) r_cnt <= '0;
      else                               r_cnt <= r_cnt + 1'b1;
      if (r_cnt == C_HM1) r_s0 <= w_rx;
      if (r_cnt == C_H)   r_s1 <= w_rx;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
          end
        end
        S_DATA: begin
          if (r_cnt == C_HP1) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          if (w_at_end)       r_bit_idx <= r_bit_idx + 1'b1;
        end
        S_PARITY: begin
          if (r_cnt == C_HP1)
            r_perr <= (PARITY == 1) ? ~(^r_shift ^ w_maj) : (^r_shift ^ w_maj);
        end
        S_STOP: begin
          if (r_cnt == C_HP1 && !w_maj) r_ferr <= 1'b1;
          if (w_at_end)                 r_stop_idx <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // receive FIFO, first-word-fall-through
  logic [EW-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [AW1-1:0] r_count;
  logic           w_pop, w_full, w_wr;
  logic [EW-1:0]  w_head;

  assign w_pop  = valid & ready;
  assign w_full = (r_count == C_FULL);
  assign w_wr   = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {r_perr, r_ferr, r_shift};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) overrun <= 1'b1;
      else if (overrun_clr)           overrun <= 1'b0;
    end
  end

  assign w_head = r_mem[r_rptr];
  assign valid  = (r_count != '0);
  assign {parity_err, frame_err, data} = valid ? w_head : '0;
  assign busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// tb_uart_rx_cfg : scoreboard bench, default instance (a) and even-parity instance (b)
module tb_uart_rx_cfg;

  localparam int P = 104;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_a, rx_b, ready_a, ready_b, clr_a, clr_b;
  logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;
  logic       ovr_a, ovr_b, busy_a, busy_b;
  logic [7:0] data_a, data_b;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_cfg u_dut_a (
    .clk(clk), .reset_n(reset_n), .rx(rx_a), .ready(ready_a), .valid(valid_a),
    .data(data_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a),
    .overrun_clr(clr_a), .busy(busy_a)
  );

  uart_rx_cfg #(.PARITY(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .rx(rx_b), .ready(ready_b), .valid(valid_b),
    .data(data_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b),
    .overrun_clr(clr_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitors: compare each popped head entry against the scoreboard
  always @(negedge clk) begin
    if (reset_n && valid_a && ready_a) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_entry: got data=0x%0h pe=%0b fe=%0b, expected none",
                 data_a, perr_a, ferr_a);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_data", data_a, e.d);
        check("a_parity_err", perr_a, e.pe);
        check("a_frame_err", ferr_a, e.fe);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && valid_b && ready_b) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_entry: got data=0x%0h pe=%0b fe=%0b, expected none",
                 data_b, perr_b, ferr_b);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_data", data_b, e.d);
        check("b_parity_err", perr_b, e.pe);
        check("b_frame_err", ferr_b, e.fe);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int inst, input logic b);
    if (inst == 0) rx_a = b;
    else           rx_b = b;
    tick(P);
  endtask

  task automatic send_frame(input int inst, input logic [7:0] d, input logic use_par,
                            input logic pbit, input logic stopb);
    drive_bit(inst, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(inst, d[i]);
    if (use_par) drive_bit(inst, pbit);
    drive_bit(inst, stopb);
    if (inst == 0) rx_a = 1'b1;
    else           rx_b = 1'b1;
  endtask

  task automatic expect_a(input logic [7:0] d, input logic pe, input logic fe);
    q_a.push_back({d, pe, fe});
  endtask

  task automatic expect_b(input logic [7:0] d, input logic pe, input logic fe);
    q_b.push_back({d, pe, fe});
  endtask

  task automatic wait_drain(input int inst, input int budget, input string name);
    int k;
    k = 0;
    while (((inst == 0) ? q_a.size() : q_b.size()) != 0 && k < budget) begin
      tick(1);
      k++;
    end
    check(name, (inst == 0) ? q_a.size() : q_b.size(), 0);
  endtask

  initial begin
    logic [7:0] part;
    reset_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0;
    tick(5);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_parity_err", perr_a, 0);
    check("rst_frame_err", ferr_a, 0);
    check("rst_overrun", ovr_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_valid_b", valid_b, 0);
    reset_n = 1'b1;
    tick(5);

    // plain frames, including all-zero / all-one data and a bad stop bit
    expect_a(8'hA5, 1'b0, 1'b0); send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    expect_a(8'h00, 1'b0, 1'b0); send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
    expect_a(8'hFF, 1'b0, 1'b0); send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    expect_a(8'h55, 1'b0, 1'b1); send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    tick(P);
    wait_drain(0, 300, "drain_basic");
    check("idle_after_bad_stop", busy_a, 0);

    // even parity: 0x07 has odd weight, so parity bit 1 is correct
    expect_b(8'h07, 1'b1, 1'b0); send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    expect_b(8'h07, 1'b0, 1'b0); send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_drain(1, 300, "drain_parity");

    // overrun: fifth frame dropped while consumer stalls
    ready_a = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) expect_a(8'(i), 1'b0, 1'b0);
      send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
    end
    check("ovr_set", ovr_a, 1);
    check("hold_valid", valid_a, 1);
    check("hold_data", data_a, 8'h01);
    tick(20);
    check("hold_data_stable", data_a, 8'h01);
    ready_a = 1'b1;
    wait_drain(0, 50, "drain_overrun");
    check("ovr_sticky", ovr_a, 1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("ovr_cleared", ovr_a, 0);

    // break: line held low for 3 frame times
    expect_a(8'h00, 1'b0, 1'b1);
    rx_a = 1'b0;
    tick(30 * P);
    check("brk_busy", busy_a, 1);
    check("brk_single_entry", q_a.size(), 0);
    rx_a = 1'b1;
    tick(4);
    check("brk_busy_release", busy_a, 0);

    // quarter-bit glitch
    tick(2 * P);
    rx_a = 1'b0;
    tick(P / 4);
    rx_a = 1'b1;
    check("glitch_busy", busy_a, 1);
    tick(P);
    check("glitch_idle", busy_a, 0);
    check("glitch_no_valid", valid_a, 0);

    // reset during data bit 4, then a clean frame
    part = 8'h0A;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, part[i]);
    rx_a = 1'b1;
    tick(P / 2);
    reset_n = 1'b0;
    tick(3);
    check("rst_mid_busy", busy_a, 0);
    check("rst_mid_valid", valid_a, 0);
    reset_n = 1'b1;
    tick(2 * P);
    expect_a(8'h3C, 1'b0, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    tick(P);
    wait_drain(0, 300, "drain_after_reset");
    check("final_queue_b", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
